// File: rtl/key_enc_pkg.sv
// rtl/key_enc_pkg.sv - shared types, constants and helpers for the key encoder
// Purpose: state encoding, width constants, 7-segment lookup, priority and
//          popcount helpers shared by key_sync and key_encoder_8to3.
// Ports:   none (package).
package key_enc_pkg;

  localparam int KEYS_N = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for digits 0..7, dp off.
  localparam logic [7:0] SEG_LUT [KEYS_N] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8
  };

  // Index of the most significant set bit; 0 when nothing is set.
  function automatic logic [CODE_W-1:0] prio(input logic [KEYS_N-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEYS_N; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [KEYS_N-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < KEYS_N; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - parameterized two-flop synchronizer, resets to all ones
// Purpose: bring asynchronous active-low key lines into the clk domain.
// Ports:   clk, rst (async, active-high), d [W-1:0] raw input,
//          q [W-1:0] synchronized output (all ones out of reset = released).
module key_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_encoder_8to3.sv
// rtl/key_encoder_8to3.sv - debounced 8-to-3 active-low priority key encoder
// Purpose: synchronize and debounce 8 active-low key lines, register the
//          highest pressed index with valid/multi flags and press/release
//          strobes.
// Ports:   clk, rst (async, active-high), key_n [7:0] raw active-low keys,
//          en (sync enable), code [2:0], valid, press_pulse, release_pulse,
//          multi, seg_n [7:0] (only when KEY_ENCODER_SEG_EN is defined).
// Config:  KEY_ENCODER_SEG_EN adds the registered 7-segment output seg_n.
module key_encoder_8to3
  import key_enc_pkg::*;
#(
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEYS_N-1:0] key_n,
  input  logic              en,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              multi
`ifdef KEY_ENCODER_SEG_EN
  ,
  output logic [7:0]        seg_n
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [KEYS_N-1:0] key_sync_n;
  logic [KEYS_N-1:0] act;

  key_sync #(.W(KEYS_N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_n),
    .q   (key_sync_n)
  );

  assign act = ~key_sync_n;

  state_t            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [KEYS_N-1:0] snap_d, snap_q;
  logic [CODE_W-1:0] code_d, code_q;
  logic              valid_d, valid_q;
  logic              multi_d, multi_q;
  logic              press_d, press_q;
  logic              release_d, release_q;
  logic              accept_press, accept_release;
`ifdef KEY_ENCODER_SEG_EN
  logic [7:0]        seg_d, seg_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_ENCODER_SEG_EN
      seg_q     <= 8'hFF;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_ENCODER_SEG_EN
      seg_q     <= seg_d;
`endif
    end
  end

  // Next state. A dropped enable forces IDLE from anywhere.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    snap_d         = snap_q;
    accept_press   = 1'b0;
    accept_release = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (act != '0) begin
            state_d = DEBOUNCE;
            snap_d  = act;
            cnt_d   = '0;
          end
        end
        DEBOUNCE: begin
          if (act == '0) begin
            state_d = IDLE;
          end else if (act != snap_q) begin
            // Key set changed mid-count: debounce the new set from scratch.
            snap_d = act;
            cnt_d  = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d      = PRESSED;
            accept_press = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (act == '0) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
        RELEASE: begin
          if (act != '0) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d        = IDLE;
            accept_release = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs; code/multi are frozen between accepted presses.
  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    multi_d   = multi_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (!en) begin
      code_d  = '0;
      valid_d = 1'b0;
      multi_d = 1'b0;
    end else if (accept_press) begin
      code_d  = prio(snap_q);
      multi_d = (popcount(snap_q) > 4'd1);
      valid_d = 1'b1;
      press_d = 1'b1;
    end else if (accept_release) begin
      valid_d   = 1'b0;
      release_d = 1'b1;
    end
`ifdef KEY_ENCODER_SEG_EN
    seg_d = valid_d ? SEG_LUT[code_d] : 8'hFF;
`endif
  end

  assign code          = code_q;
  assign valid         = valid_q;
  assign multi         = multi_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
`ifdef KEY_ENCODER_SEG_EN
  assign seg_n         = seg_q;
`endif

endmodule

// File: tb/tb_key_encoder_8to3.sv
// tb/tb_key_encoder_8to3.sv - self-checking bench for key_encoder_8to3
module tb_key_encoder_8to3;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_n;
  logic       en;
  logic [2:0] code;
  logic       valid, press_pulse, release_pulse, multi;
`ifdef KEY_ENCODER_SEG_EN
  logic [7:0] seg_n;
`endif

  key_encoder_8to3 #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_n         (key_n),
    .en            (en),
    .code          (code),
    .valid         (valid),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .multi         (multi)
`ifdef KEY_ENCODER_SEG_EN
    ,
    .seg_n         (seg_n)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: input delay line plus run lengths of identical samples.
  logic [7:0] ms1, ms2, m_last;
  int         run;
  logic       m_valid, m_multi, m_press, m_rel;
  int         m_code;

  function automatic logic [7:0] seg_ref(input logic v, input int c);
    if (!v) return 8'hFF;
    case (c)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  default: return 8'hF8;
    endcase
  endfunction

  task automatic mdl_reset();
    ms1 = 8'hFF; ms2 = 8'hFF; m_last = 8'h00; run = 0;
    m_valid = 0; m_multi = 0; m_press = 0; m_rel = 0; m_code = 0;
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    vectors++;
    if (act_v != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // One clock: advance the model with the inputs that the edge will sample,
  // then compare every output just after the edge.
  task automatic tick();
    logic [7:0] a;
    int hi;
    a = ~ms2;
    ms2 = ms1;
    ms1 = key_n;
    m_press = 0;
    m_rel = 0;
    if (!en) begin
      m_valid = 0; m_code = 0; m_multi = 0; run = 0;
    end else if (!m_valid) begin
      if (a == 0) run = 0;
      else if (run > 0 && a == m_last) run++;
      else run = 1;
      m_last = a;
      if (run == DB + 1) begin
        hi = 0;
        for (int i = 0; i < 8; i++) if (a[i]) hi = i;
        m_valid = 1; m_code = hi; m_multi = ($countones(a) > 1); m_press = 1; run = 0;
      end
    end else begin
      if (a == 0) run++; else run = 0;
      if (run == DB + 1) begin
        m_valid = 0; m_rel = 1; run = 0;
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (int'(code) != m_code || valid !== m_valid || multi !== m_multi ||
        press_pulse !== m_press || release_pulse !== m_rel
`ifdef KEY_ENCODER_SEG_EN
        || seg_n !== seg_ref(m_valid, m_code)
`endif
       ) begin
      miscompares++;
      $display("FAIL cycle_model at %0t: code=%0d/%0d valid=%b/%b multi=%b/%b press=%b/%b rel=%b/%b",
               $time, code, m_code, valid, m_valid, multi, m_multi,
               press_pulse, m_press, release_pulse, m_rel);
    end
  endtask

  // Assert rst away from the edge, check outputs cleared at once, then
  // hold it across one edge and release.
  task automatic async_reset(input string name);
    #2;
    rst = 1'b1;
    #1;
    chk(name, {code, valid, multi, press_pulse, release_pulse}, 0);
    mdl_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] key_n;
    int         exp_code;
    int         exp_multi;
  } vec_t;

  vec_t tbl[8];
  int   n, lat;

  initial begin
    tbl[0] = '{8'hFE, 0, 0};
    tbl[1] = '{8'b1101_1011, 5, 1};
    tbl[2] = '{8'b0111_1111, 7, 0};
    tbl[3] = '{8'hF7, 3, 0};
    tbl[4] = '{8'hFB, 2, 0};
    tbl[5] = '{8'h00, 7, 1};
    tbl[6] = '{8'hFD, 1, 0};
    tbl[7] = '{8'hE0, 4, 1};

    rst = 1'b1; en = 1'b1; key_n = 8'hFF;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: nothing happens for 20 cycles.
    n = 0;
    repeat (20) begin tick(); n += press_pulse + release_pulse; end
    chk("idle_strobes", n, 0);
    chk("idle_valid", valid, 0);

    // Press / release latency, counted in edges after the key change.
    key_n = 8'hFE; lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin tick(); if (press_pulse) lat = i; end
    chk("press_latency", lat, DB + 3);
    repeat (3) tick();
    key_n = 8'hFF; lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin tick(); if (release_pulse) lat = i; end
    chk("release_latency", lat, DB + 3);
    chk("release_valid", valid, 0);
    repeat (3) tick();

    // Table of stable presses, each followed by a full release.
    for (int t = 0; t < 8; t++) begin
      key_n = tbl[t].key_n; n = 0;
      repeat (DB + 6) begin tick(); n += press_pulse; end
      chk("tbl_press_count", n, 1);
      chk("tbl_code", code, tbl[t].exp_code);
      chk("tbl_multi", multi, tbl[t].exp_multi);
      chk("tbl_valid", valid, 1);
`ifdef KEY_ENCODER_SEG_EN
      chk("tbl_seg", seg_n, seg_ref(1'b1, tbl[t].exp_code));
`endif
      key_n = 8'hFF; n = 0;
      repeat (DB + 6) begin tick(); n += release_pulse; end
      chk("tbl_release_count", n, 1);
      chk("tbl_release_valid", valid, 0);
`ifdef KEY_ENCODER_SEG_EN
      chk("tbl_seg_idle", seg_n, 8'hFF);
`endif
    end

    // Bounce while pressing, then a short glitch while held.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      key_n = i[0] ? 8'hFF : 8'hF7;
      repeat (2) begin tick(); n += press_pulse; end
    end
    key_n = 8'hF7;
    repeat (DB + 8) begin tick(); n += press_pulse; end
    chk("bounce_press_count", n, 1);
    chk("bounce_code", code, 3);
    key_n = 8'hFF; n = 0;
    repeat (2) begin tick(); n += release_pulse; end
    key_n = 8'hF7;
    repeat (8) begin tick(); n += release_pulse; end
    chk("glitch_no_release", n, 0);
    chk("glitch_valid", valid, 1);

    // Enable dropped while valid, then raised with the key still held.
    en = 1'b0;
    tick();
    chk("en_low_valid", valid, 0);
    chk("en_low_code", code, 0);
    chk("en_low_release", release_pulse, 0);
    en = 1'b1; lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin tick(); if (press_pulse) lat = i; end
    chk("en_rise_latency", lat, DB + 1);
    key_n = 8'hFF;
    repeat (DB + 6) tick();

    // Reset mid-debounce and mid-press, key kept held afterwards.
    key_n = 8'hFB;
    repeat (4) tick();
    async_reset("rst_debounce_outputs");
    n = 0;
    repeat (DB + 8) begin tick(); n += press_pulse + release_pulse; end
    chk("rst_debounce_fresh_press", n, 1);
    async_reset("rst_pressed_outputs");
    n = 0;
    repeat (DB + 8) begin tick(); n += release_pulse; end
    chk("rst_pressed_no_release", n, 0);
    key_n = 8'hFF;
    repeat (DB + 6) tick();

    // Randomized segments checked cycle by cycle against the model.
    for (int s = 0; s < 60; s++) begin
      key_n = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 9)) tick();
    end
    en = 1'b1; key_n = 8'hFF;
    repeat (DB + 6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
